// File: rtl/sfifo_if.sv
// Handshake and status bundle between an sfifo and its user.
// master drives requests and thresholds; slave is the FIFO itself.
interface sfifo_if #(
  parameter int DEEPWID = 4,
  parameter int BITWID  = 8
) ();
  logic               flush;
  logic               wr;
  logic [BITWID-1:0]  wr_dat;
  logic               rd;
  logic [BITWID-1:0]  rd_dat;
  logic               rd_dat_vld;
  logic [DEEPWID:0]   cfg_almost_full;
  logic [DEEPWID:0]   cfg_almost_empty;
  logic               almost_full;
  logic               almost_empty;
  logic               full;
  logic               empty;
  logic [DEEPWID:0]   num;
  logic               overflow;
  logic               underflow;
  logic               err_clr;

  modport master (
    output flush, wr, wr_dat, rd, cfg_almost_full, cfg_almost_empty, err_clr,
    input  rd_dat, rd_dat_vld, almost_full, almost_empty, full, empty, num,
           overflow, underflow
  );

  modport slave (
    input  flush, wr, wr_dat, rd, cfg_almost_full, cfg_almost_empty, err_clr,
    output rd_dat, rd_dat_vld, almost_full, almost_empty, full, empty, num,
           overflow, underflow
  );
endinterface

// File: rtl/sfifo.sv
// Single-clock FIFO, any depth; MODE 0 read data 1 cycle after rd, MODE 1 first-word-fall-through.
// Writes dropped while full, reads dropped while empty; both leave sticky error flags.
module sfifo #(
  parameter int DEEPWID = 4,
  parameter int DEEP    = 12,
  parameter int BITWID  = 8,
  parameter int MODE    = 0
) (
  input  logic     clk,
  input  logic     rst,
  sfifo_if.slave   bus
);
  localparam logic [DEEPWID-1:0] LAST   = DEEPWID'(DEEP - 1);
  localparam logic [DEEPWID:0]   DEEP_N = (DEEPWID + 1)'(DEEP);

  logic [BITWID-1:0]  mem_q [DEEP];
  logic [DEEPWID-1:0] wptr_q, wptr_d;
  logic [DEEPWID-1:0] rptr_q, rptr_d;
  logic [DEEPWID:0]   num_q, num_d;
  logic               ovf_q, ovf_d;
  logic               udf_q, udf_d;
  logic               full, empty, wr_acc, rd_acc;

  assign full   = (num_q == DEEP_N);
  assign empty  = (num_q == '0);
  assign wr_acc = bus.wr & ~full & ~bus.flush;
  assign rd_acc = bus.rd & ~empty & ~bus.flush;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    num_d  = num_q;
    if (bus.flush) begin
      wptr_d = '0;
      rptr_d = '0;
      num_d  = '0;
    end else begin
      // Explicit wrap so non-power-of-two depths work.
      if (wr_acc) wptr_d = (wptr_q == LAST) ? '0 : wptr_q + 1'b1;
      if (rd_acc) rptr_d = (rptr_q == LAST) ? '0 : rptr_q + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   num_d = num_q + 1'b1;
        2'b01:   num_d = num_q - 1'b1;
        default: num_d = num_q;
      endcase
    end
    // Set has priority over err_clr.
    ovf_d = (ovf_q & ~bus.err_clr) | (bus.wr & full & ~bus.flush);
    udf_d = (udf_q & ~bus.err_clr) | (bus.rd & empty & ~bus.flush);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      num_q  <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      num_q  <= num_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wptr_q] <= bus.wr_dat;
  end

  generate
    if (MODE == 0) begin : g_reg
      logic [BITWID-1:0] rd_dat_q, rd_dat_d;
      logic              rd_vld_q, rd_vld_d;

      always_comb begin
        rd_dat_d = rd_acc ? mem_q[rptr_q] : rd_dat_q;
        rd_vld_d = rd_acc;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_dat_q <= '0;
          rd_vld_q <= 1'b0;
        end else begin
          rd_dat_q <= rd_dat_d;
          rd_vld_q <= rd_vld_d;
        end
      end

      assign bus.rd_dat     = rd_dat_q;
      assign bus.rd_dat_vld = rd_vld_q;
    end else begin : g_fwft
      assign bus.rd_dat     = empty ? '0 : mem_q[rptr_q];
      assign bus.rd_dat_vld = ~empty;
    end
  endgenerate

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.num          = num_q;
  assign bus.almost_full  = (num_q >= bus.cfg_almost_full);
  assign bus.almost_empty = (num_q <= bus.cfg_almost_empty);
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_sfifo.sv
// Bench for sfifo: registered-read and FWFT instances, read data checked by a scoreboard monitor.
module tb_sfifo;
  localparam int DW   = 4;
  localparam int DEEP = 12;
  localparam int BW   = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sfifo_if #(.DEEPWID(DW), .BITWID(BW)) bus0 ();
  sfifo_if #(.DEEPWID(DW), .BITWID(BW)) bus1 ();

  sfifo #(.DEEPWID(DW), .DEEP(DEEP), .BITWID(BW), .MODE(0)) u_reg  (.clk(clk), .rst(rst), .bus(bus0));
  sfifo #(.DEEPWID(DW), .DEEP(DEEP), .BITWID(BW), .MODE(1)) u_fwft (.clk(clk), .rst(rst), .bus(bus1));

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] mq[$];
  logic [7:0] exp0[$];
  logic [7:0] exp1[$];
  int         mnum;
  logic       ovf_m, udf_m;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Registered-read scoreboard: every rd_dat_vld must match the oldest expected word.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus0.rd_dat_vld === 1'b1) begin
      if (exp0.size() == 0) chk("reg_spurious_vld", 1, 0);
      else                  chk("reg_rd_dat", bus0.rd_dat, exp0.pop_front());
    end
  end

  // FWFT scoreboard: head consumed when rd meets rd_dat_vld.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus1.rd === 1'b1 && bus1.rd_dat_vld === 1'b1) begin
      if (exp1.size() == 0) chk("fwft_spurious_pop", 1, 0);
      else                  chk("fwft_rd_dat", bus1.rd_dat, exp1.pop_front());
    end
  end

  task automatic step(input logic w, input logic [7:0] d, input logic r,
                      input logic fl = 1'b0, input logic ec = 1'b0);
    logic full_m, empty_m, wacc, racc;
    bus0.wr = w; bus0.wr_dat = d; bus0.rd = r; bus0.flush = fl; bus0.err_clr = ec;
    full_m  = (mnum == DEEP);
    empty_m = (mnum == 0);
    wacc    = w & ~full_m & ~fl;
    racc    = r & ~empty_m & ~fl;
    ovf_m   = (ovf_m & ~ec) | (w & full_m & ~fl);
    udf_m   = (udf_m & ~ec) | (r & empty_m & ~fl);
    if (fl) begin
      mq.delete();
      mnum = 0;
    end else begin
      if (racc) begin exp0.push_back(mq.pop_front()); mnum--; end
      if (wacc) begin mq.push_back(d); mnum++; end
    end
    @(posedge clk); #1;
    bus0.wr = 1'b0; bus0.rd = 1'b0; bus0.flush = 1'b0; bus0.err_clr = 1'b0;
    chk("num", bus0.num, mnum);
    chk("full", bus0.full, mnum == DEEP);
    chk("empty", bus0.empty, mnum == 0);
    chk("overflow", bus0.overflow, ovf_m);
    chk("underflow", bus0.underflow, udf_m);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus0.wr = 0; bus0.wr_dat = 0; bus0.rd = 0; bus0.flush = 0; bus0.err_clr = 0;
    bus1.wr = 0; bus1.wr_dat = 0; bus1.rd = 0; bus1.flush = 0; bus1.err_clr = 0;
    bus0.cfg_almost_full = 5'd10; bus0.cfg_almost_empty = 5'd2;
    bus1.cfg_almost_full = 5'd10; bus1.cfg_almost_empty = 5'd2;
    mnum = 0; ovf_m = 0; udf_m = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_num", bus0.num, 0);
    chk("rst_empty", bus0.empty, 1);
    chk("rst_full", bus0.full, 0);
    chk("rst_almost_empty", bus0.almost_empty, 1);
    chk("rst_almost_full", bus0.almost_full, 0);
    chk("rst_vld", bus0.rd_dat_vld, 0);
    chk("rst_rd_dat", bus0.rd_dat, 0);
    chk("rst_overflow", bus0.overflow, 0);
    chk("rst_underflow", bus0.underflow, 0);
    chk("rst_fwft_vld", bus1.rd_dat_vld, 0);
    chk("rst_fwft_rd_dat", bus1.rd_dat, 0);
    rst = 1'b0;

    // Fill 0x01..0x0C with threshold checks, then one write too many.
    for (int i = 1; i <= 12; i++) begin
      step(1, 8'(i), 0);
      chk("almost_empty", bus0.almost_empty, i <= 2);
      chk("almost_full", bus0.almost_full, i >= 10);
    end
    step(1, 8'hDD, 0);
    chk("ovf_after_13th", bus0.overflow, 1);
    for (int i = 1; i <= 12; i++) step(0, 8'h00, 1);
    step(0, 8'h00, 1);
    chk("no_vld_13th_read", bus0.rd_dat_vld, 0);
    chk("udf_after_13th", bus0.underflow, 1);
    step(0, 8'h00, 0, 0, 1);

    // Simultaneous wr+rd at 5 and at full.
    for (int i = 0; i < 5; i++) step(1, 8'h21 + 8'(i), 0);
    step(1, 8'h26, 1);
    step(1, 8'h27, 1);
    chk("num_wr_rd_at5", bus0.num, 5);
    for (int i = 0; i < 7; i++) step(1, 8'h30 + 8'(i), 0);
    step(1, 8'hEE, 1);
    chk("num_wr_rd_at12", bus0.num, 11);
    chk("ovf_wr_rd_at12", bus0.overflow, 1);
    while (mnum > 0) step(0, 8'h00, 1);
    step(0, 8'h00, 0, 0, 1);

    // Random traffic across the 11 -> 0 pointer wrap, occupancy kept in 1..11.
    step(1, 8'h40, 0);
    for (int k = 1; k <= 40; k++) begin
      logic w, r;
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      if (mnum <= 1)  r = 1'b0;
      if (mnum >= 11) w = 1'b0;
      step(w, 8'h40 + 8'(k), r);
    end
    while (mnum > 0) step(0, 8'h00, 1);

    // Flush at num 7 with overflow already set and a write pending.
    for (int i = 0; i < 12; i++) step(1, 8'h50 + 8'(i), 0);
    step(1, 8'hDD, 0);
    for (int i = 0; i < 5; i++) step(0, 8'h00, 1);
    chk("num_before_flush", bus0.num, 7);
    step(1, 8'h77, 0, 1);
    chk("flush_num", bus0.num, 0);
    chk("flush_empty", bus0.empty, 1);
    chk("flush_vld", bus0.rd_dat_vld, 0);
    chk("flush_keeps_ovf", bus0.overflow, 1);
    step(0, 8'h00, 1);
    chk("flush_no_write_udf", bus0.underflow, 1);

    // err_clr colliding with a fresh overflow.
    step(0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 12; i++) step(1, 8'h60 + 8'(i), 0);
    chk("ovf_cleared", bus0.overflow, 0);
    step(1, 8'h99, 0, 0, 1);
    chk("ovf_set_beats_clr", bus0.overflow, 1);

    // FWFT instance.
    bus1.wr = 1; bus1.wr_dat = 8'hA5;
    @(posedge clk); #1;
    bus1.wr = 0;
    chk("fwft_dat_n1", bus1.rd_dat, 8'hA5);
    chk("fwft_vld_n1", bus1.rd_dat_vld, 1);
    bus1.rd = 1; exp1.push_back(8'hA5);
    @(posedge clk); #1;
    bus1.rd = 0;
    chk("fwft_empty_n2", bus1.empty, 1);
    chk("fwft_dat_n2", bus1.rd_dat, 0);
    chk("fwft_vld_n2", bus1.rd_dat_vld, 0);
    for (int i = 0; i < 3; i++) begin
      bus1.wr = 1; bus1.wr_dat = 8'hB1 + 8'(i);
      @(posedge clk); #1;
    end
    bus1.wr = 0;
    for (int i = 0; i < 3; i++) begin
      bus1.rd = 1; exp1.push_back(8'hB1 + 8'(i));
      @(posedge clk); #1;
      chk("fwft_num", bus1.num, 2 - i);
    end
    @(posedge clk); #1;
    chk("fwft_underflow", bus1.underflow, 1);
    bus1.rd = 0;

    // Asynchronous reset mid-stream.
    bus1.wr = 1; bus1.wr_dat = 8'h3C;
    step(0, 8'h00, 1);
    bus1.wr = 0;
    step(0, 8'h00, 0);
    chk("fwft_vld_pre_rst", bus1.rd_dat_vld, 1);
    rst = 1'b1;
    #2;
    chk("arst_num", bus0.num, 0);
    chk("arst_empty", bus0.empty, 1);
    chk("arst_full", bus0.full, 0);
    chk("arst_overflow", bus0.overflow, 0);
    chk("arst_rd_dat", bus0.rd_dat, 0);
    chk("arst_vld", bus0.rd_dat_vld, 0);
    chk("arst_fwft_vld", bus1.rd_dat_vld, 0);
    chk("arst_fwft_rd_dat", bus1.rd_dat, 0);
    chk("arst_fwft_underflow", bus1.underflow, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    mq.delete(); mnum = 0; ovf_m = 0; udf_m = 0;
    step(1, 8'h5A, 0);
    step(0, 8'h00, 1);
    step(0, 8'h00, 0);

    chk("reg_scoreboard_drained", exp0.size(), 0);
    chk("fwft_scoreboard_drained", exp1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sfifo.md
# sfifo

Parametrised single-clock FIFO, the synchronous successor of the team's dual-clock FIFO, for buffering inside one clock domain. Generalised in depth (any DEEP, not only powers of two), data width and read mode (registered read or first-word-fall-through). Adds synchronous flush, sticky overflow/underflow error flags and a single occupancy count.

## Interface
- DEEPWID, 4: pointer width; DEEP must satisfy 2 <= DEEP <= 2^DEEPWID.
- DEEP, 12: number of storage entries; non-power-of-two allowed.
- BITWID, 8: data width.
- MODE, 0: 0 = registered read (data one cycle after rd); 1 = first-word-fall-through (FWFT).
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of contents.
- wr  in  1  write request.
- wr_dat  in  BITWID  write data.
- rd  in  1  read request (MODE 0) / head acknowledge (MODE 1).
- rd_dat  out  BITWID  read data.
- rd_dat_vld  out  1  rd_dat valid.
- cfg_almost_full  in  DEEPWID+1  almost_full threshold.
- cfg_almost_empty  in  DEEPWID+1  almost_empty threshold.
- almost_full  out  1  num >= cfg_almost_full.
- almost_empty  out  1  num <= cfg_almost_empty.
- full  out  1  num == DEEP.
- empty  out  1  num == 0.
- num  out  DEEPWID+1  entries held in storage.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.
- err_clr  in  1  clears overflow and underflow.

## Operation
- Storage: DEEP x BITWID array, not reset. Write pointer and read pointer each run 0..DEEP-1 and wrap from DEEP-1 to 0, including for non-power-of-two DEEP.
- Write accepted iff wr & ~full & ~flush. Stores wr_dat at the write pointer and advances it.
- Read accepted iff rd & ~empty & ~flush. Advances the read pointer.
- full and empty are sampled from the registered num at the start of the cycle. There is no write-through when full, even with a simultaneous read.
- num: +1 on write only, -1 on read only, unchanged when both or neither are accepted. Saturation is impossible by construction.
- Flags: full, empty, almost_full and almost_empty are decoded combinationally from registered num only (no input-to-output paths).
- MODE 0:
  - On an accepted read, rd_dat is loaded with the head entry at the edge; rd_dat_vld is 1 for exactly that following cycle.
  - rd_dat holds its last value otherwise.
- MODE 1:
  - rd_dat = head entry whenever ~empty; rd_dat = 0 when empty.
  - rd_dat_vld = ~empty.
  - An accepted rd pops the head; the next entry (if any) is visible in the following cycle.
- overflow is set by wr & full & ~flush. underflow is set by rd & empty & ~flush.
  - Both are sticky until err_clr.
  - If set and clear occur in the same cycle, set wins.
- flush:
  - Next edge: both pointers = 0, num = 0, rd_dat_vld = 0.
  - wr and rd in the flush cycle are ignored and raise no error.
  - overflow and underflow are not affected.
  - MODE 0 rd_dat keeps its value.
- cfg_* values are used as given; cfg_almost_full = 0 gives almost_full constantly 1.

## Timing
- Reset (rst high, asynchronous):
  - Pointers, num, rd_dat_vld, overflow and underflow = 0; rd_dat = 0.
  - Hence empty = 1, full = 0, almost_empty = 1, almost_full = (cfg_almost_full == 0).
- The first edge after rst deasserts may accept a write.
- Reset mid-operation discards all contents immediately; no partial write is committed.
- Write-to-flag latency: 1 cycle (num updates at the accepting edge).
- MODE 0 read latency: rd at cycle N -> rd_dat/rd_dat_vld at cycle N+1. Back-to-back reads give one entry per cycle.
- MODE 1: a write into an empty FIFO at cycle N -> rd_dat_vld = 1 and data visible at cycle N+1.
- Throughput: one write and one read per cycle sustained at any occupancy between 1 and DEEP-1.

## Test plan
- **Fill/drain, DEEP=12, MODE 0:** write 12 words 0x01..0x0C, then a 13th write.
  - full = 1 after the 12th; num = 12; 13th ignored; overflow = 1.
  - 12 reads return 0x01..0x0C, each with rd_dat_vld one cycle later.
  - A 13th read sets underflow = 1 and gives no rd_dat_vld.
- **Wrap-around, DEEP=12:** 40 cycles of random wr/rd keeping num between 1 and 11.
  - Read order matches write order across pointer wrap at 11 -> 0.
  - num tracks a reference model every cycle.
- **Simultaneous wr+rd:** at num = 5, and at num = 12 with wr+rd.
  - At 5, num stays 5 and data order is preserved.
  - At 12, the read is accepted, the write is dropped, num = 11, overflow = 1.
- **Thresholds:** cfg_almost_full = 10, cfg_almost_empty = 2.
  - almost_empty = 1 at num 0..2, 0 at num 3.
  - almost_full = 0 at num 9, 1 at num 10.
- **MODE 1 FWFT:** write 0xA5 into an empty FIFO at cycle N.
  - Cycle N+1: rd_dat = 0xA5, rd_dat_vld = 1.
  - rd at N+1 -> cycle N+2: empty = 1, rd_dat = 0, rd_dat_vld = 0.
- **flush and err_clr, then rst:**
  - flush at num = 7 with wr = 1 -> next cycle num = 0, empty = 1, no write stored, overflow unchanged.
  - err_clr together with a new overflow event -> overflow stays 1.
  - rst pulse mid-stream -> all outputs take their reset values immediately.
